// File: rtl/arith_pkg.sv
// Shared types and constants for the arith_pipe datapath: operation codes and flag layout.
package arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_MIN = 3'd6,
        OP_MAX = 3'd7
    } op_t;

    localparam int FLAG_W     = 3;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 2;

endpackage

// File: rtl/arith_core.sv
// Combinational ALU for arith_pipe: result plus {carry, overflow, zero}.
// Saturating ADD/SUB/MUL is compiled in only when ARITH_PIPE_SAT_EN is defined.
module arith_core import arith_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  op_t               op,
    input  logic              is_signed,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    logic [WIDTH:0]         sum_s;
    logic [WIDTH:0]         diff_s;
    logic [2*WIDTH-1:0]     prod_u_s;
    logic [2*WIDTH-1:0]     prod_s_s;
    logic                   add_ovf_s;
    logic                   sub_ovf_s;
    logic                   mul_ovf_s;
    logic                   b_lt_a_s;
    logic                   b_gt_a_s;
    logic [WIDTH-1:0]       raw_s;
    logic                   carry_s;
    logic                   ovf_s;
    logic                   pos_dir_s;
    logic                   arith_op_s;

    assign sum_s    = {1'b0, a} + {1'b0, b};
    assign diff_s   = {1'b0, a} - {1'b0, b};
    assign prod_u_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Sign-extended operands give the exact signed product in 2*WIDTH bits.
    assign prod_s_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

    assign add_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
    assign mul_ovf_s = (prod_s_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_s_s[WIDTH-1]}});

    assign b_lt_a_s = is_signed ? ($signed(b) < $signed(a)) : (b < a);
    assign b_gt_a_s = is_signed ? ($signed(b) > $signed(a)) : (b > a);

    // Raw result and unmasked status per operation; ties in MIN/MAX keep A.
    always_comb begin
        raw_s      = {WIDTH{1'b0}};
        carry_s    = 1'b0;
        ovf_s      = 1'b0;
        pos_dir_s  = 1'b0;
        arith_op_s = 1'b0;
        case (op)
            OP_ADD: begin
                raw_s      = sum_s[WIDTH-1:0];
                carry_s    = sum_s[WIDTH];
                ovf_s      = add_ovf_s;
                pos_dir_s  = ~a[WIDTH-1];
                arith_op_s = 1'b1;
            end
            OP_SUB: begin
                raw_s      = diff_s[WIDTH-1:0];
                carry_s    = diff_s[WIDTH];
                ovf_s      = sub_ovf_s;
                pos_dir_s  = ~a[WIDTH-1];
                arith_op_s = 1'b1;
            end
            OP_MUL: begin
                raw_s      = prod_u_s[WIDTH-1:0];
                carry_s    = |prod_u_s[2*WIDTH-1:WIDTH];
                ovf_s      = mul_ovf_s;
                pos_dir_s  = ~(a[WIDTH-1] ^ b[WIDTH-1]);
                arith_op_s = 1'b1;
            end
            OP_AND:  raw_s = a & b;
            OP_OR:   raw_s = a | b;
            OP_XOR:  raw_s = a ^ b;
            OP_MIN:  raw_s = b_lt_a_s ? b : a;
            OP_MAX:  raw_s = b_gt_a_s ? b : a;
            default: raw_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef ARITH_PIPE_SAT_EN
    // Clamp on the condition the flags report: overflow when signed, carry/borrow when unsigned.
    always_comb begin
        result = raw_s;
        if (arith_op_s && is_signed && ovf_s) begin
            result = pos_dir_s ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end else if (arith_op_s && !is_signed && carry_s) begin
            result = (op == OP_SUB) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end else begin
            result = raw_s;
        end
    end
`else
    assign result = raw_s;
`endif

    assign flags[FLAG_CARRY] = carry_s;
    assign flags[FLAG_OVF]   = ovf_s & is_signed;
    assign flags[FLAG_ZERO]  = (result == {WIDTH{1'b0}});

endmodule

// File: rtl/arith_pipe.sv
// Two-stage valid/ready arithmetic pipeline with a completed-result counter.
// Build option: ARITH_PIPE_SAT_EN enables saturating ADD/SUB/MUL in arith_core.
module arith_pipe import arith_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  data_1,
    input  logic [WIDTH-1:0]  data_2,
    input  logic [2:0]        op_sel,
    input  logic              is_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic [FLAG_W-1:0] flags,
    output logic [CNT_W-1:0]  done_count
);

    logic               s1_valid_r;
    logic [WIDTH-1:0]   s1_a_r;
    logic [WIDTH-1:0]   s1_b_r;
    op_t                s1_op_r;
    logic               s1_signed_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   data_out_r;
    logic [FLAG_W-1:0]  flags_r;
    logic [CNT_W-1:0]   done_count_r;
    logic               s2_adv_s;
    logic               s1_adv_s;
    logic [WIDTH-1:0]   core_result_s;
    logic [FLAG_W-1:0]  core_flags_s;

    assign s2_adv_s = !out_valid_r || out_ready;
    assign s1_adv_s = !s1_valid_r || s2_adv_s;
    assign in_ready = s1_adv_s;

    arith_core #(.WIDTH(WIDTH)) u_core (
        .a         (s1_a_r),
        .b         (s1_b_r),
        .op        (s1_op_r),
        .is_signed (s1_signed_r),
        .result    (core_result_s),
        .flags     (core_flags_s)
    );

    // Stage 1: operand capture on an input transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= {WIDTH{1'b0}};
            s1_b_r      <= {WIDTH{1'b0}};
            s1_op_r     <= OP_ADD;
            s1_signed_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r      <= data_1;
                s1_b_r      <= data_2;
                s1_op_r     <= op_t'(op_sel);
                s1_signed_r <= is_signed;
            end
        end
    end

    // Stage 2: result register, frozen while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            data_out_r  <= {WIDTH{1'b0}};
            flags_r     <= {FLAG_W{1'b0}};
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                data_out_r <= core_result_s;
                flags_r    <= core_flags_s;
            end
        end
    end

    // Count consumed results; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_count_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && out_ready) begin
            done_count_r <= done_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid  = out_valid_r;
    assign data_out   = data_out_r;
    assign flags      = flags_r;
    assign done_count = done_count_r;

endmodule
